sram_word_store: RTL and testbench
==================================

# sram_word_store

Synchronous single-bank word store on the SRAM side of the AXI slave interface. It consumes the peripheral-width read port (address plus output enable, one-cycle registered data) and write port (address, data, byte enables, strobe). It provides a post-reset zero-clear sequencer, read-during-write forwarding, out-of-range detection, and access counters. Read data is returned on the cycle after `SRAM_OUTPUT_ENABLE`, which is the latency the slave interface's read path samples at.

## Interface
- `addr_bits`, 19: word-address width; matches the slave's `width - p_size`.
- `p_size`, 3: word width is 2^p_size bytes; data width is 8<<p_size bits.
- `depth`, 4096: implemented words; valid addresses are 0..depth-1; must be ≤ 2^addr_bits.
- `init_zero`, 1: when 1, memory is zero-cleared after every reset.

Ports:
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset; synchronous, active-low.
- `SRAM_READ_ADDRESS` in `addr_bits`: read word address.
- `SRAM_OUTPUT_ENABLE` in 1: read request this cycle.
- `SRAM_READ_DATA` out 8<<p_size: registered read data.
- `SRAM_WRITE_ADDRESS` in `addr_bits`: write word address.
- `SRAM_WRITE_DATA` in 8<<p_size: write data.
- `SRAM_WRITE_BYTE_ENABLE` in 1<<p_size: per-byte write enable.
- `SRAM_WRITE_STROBE` in 1: write this cycle.
- `INIT_DONE` out 1: store is accepting accesses.
- `ERR` out 1: sticky error flag.
- `RD_COUNT` out 32: accepted reads, saturating.
- `WR_COUNT` out 32: accepted writes, saturating.

## Operation
- **States:** CLEAR, READY. `INIT_DONE` = (state == READY).
- **Reset** (ARESETn=0 at an edge):
  - State becomes CLEAR if init_zero=1, else READY.
  - Clear pointer is set to 0.
  - `SRAM_READ_DATA` is set to 0, `ERR` to 0, `RD_COUNT` and `WR_COUNT` to 0.
  - Array contents are not reset.
- **CLEAR:**
  - Each edge writes all-zero to word[ptr] and increments ptr.
  - The edge that writes word depth-1 moves the state to READY.
  - Port writes are dropped and set `ERR`.
  - Port reads load 0 into `SRAM_READ_DATA` and set `ERR`.
  - Neither counter increments.
- **READY write:** on an edge with STROBE=1 and address < depth:
  - For each byte b with BE[b]=1, word[addr] byte b takes DATA byte b; other bytes are unchanged.
  - `WR_COUNT` increments.
  - BE=0 still counts as an accepted write and changes no data.
- **READY read:** on an edge with OE=1 and address < depth:
  - `SRAM_READ_DATA` loads word[addr] and `RD_COUNT` increments.
  - With OE=0, `SRAM_READ_DATA` holds its value.
- **Read-during-write, same address, same edge:** write-first.
  - `SRAM_READ_DATA` = old word with the enabled bytes replaced by write data.
  - Both counters increment.
- **Out of range** (address ≥ depth):
  - A write is dropped.
  - A read loads all-ones.
  - Either sets `ERR`; counters do not increment.
- **Simultaneous read and write, different addresses:** both complete independently in the same edge.
- **Counters:** 32-bit, saturate at 32'hFFFFFFFF with no wrap.
- **ERR:** sticky; cleared only by reset.
- **Reset mid-CLEAR:** the sweep restarts at word 0; the full depth-cycle sweep is repeated.

## Timing
- **Read latency:** 1 cycle. OE sampled at edge N gives data valid after edge N, stable through edge N+1. The slave's `read_partial_data_valid` stage samples it combinationally in that window.
- **Write latency:** a write at edge N is visible to a read sampled at edge N (forwarding) and to all later reads.
- **No handshake:** the store never stalls, and every READY-state access completes in one edge.
- **Clear duration:** with the first edge after ARESETn=1 counted as edge 0, words 0..depth-1 are cleared at edges 0..depth-1. `INIT_DONE` is 1 after edge depth-1, and the first accepted access is at edge depth.
- **init_zero=0:** `INIT_DONE` is 1 immediately after the reset edge.
- **Array:** the array is inferred as a single memory with one read and one write port. Forwarding is implemented with compare and merge logic on the registered read path.

## Test plan
- **Clear:** init_zero=1, depth=16, pre-load word 5 = 64'hDEAD_BEEF_0123_4567 via a backdoor, release reset.
  - `INIT_DONE` rises after edge 15.
  - A read of word 5 at edge 16 returns 0; `ERR`=0.
- **Byte lanes:** write 64'h1122334455667788 with BE=8'hFF to word 3, then 64'hAAAAAAAAAAAAAAAA with BE=8'h0F.
  - A read of word 3 returns 64'h11223344AAAAAAAA after 1 cycle.
  - `WR_COUNT`=2, `RD_COUNT`=1.
- **Forwarding:** word 7 = 0, then in one cycle write 64'hFF with BE=8'h01 to word 7 and read word 7.
  - Next cycle `SRAM_READ_DATA`=64'h00000000000000FF.
- **Out of range:** depth=16, read address 20.
  - `SRAM_READ_DATA`=all-ones, `ERR`=1, `RD_COUNT` unchanged.
  - A following valid read still works, and `ERR` stays 1 until reset.
- **Access during CLEAR:** write at clear edge 4 is dropped and sets `ERR`.
  - Reset asserted at clear edge 8 restarts the sweep; `INIT_DONE` comes 16 edges after release.
- **Counter saturation:** force `WR_COUNT`=32'hFFFFFFFE, then do 3 writes.
  - `WR_COUNT` ends at 32'hFFFFFFFF.

Source files
------------

// File: rtl/sram_word_store_if.sv
// SRAM-side read/write port bundle between the AXI slave and the word store.
// Latency: none (wires only); read data is returned by the store one edge after OE.
// Backpressure: none; every access on these signals is taken in the cycle it is driven.
interface sram_word_store_if #(
   parameter int addr_bits = 19,
   parameter int p_size    = 3
);
   localparam int DW = 8 << p_size;
   localparam int NB = 1 << p_size;

   logic [addr_bits-1:0] SRAM_READ_ADDRESS;
   logic                 SRAM_OUTPUT_ENABLE;
   logic [DW-1:0]        SRAM_READ_DATA;
   logic [addr_bits-1:0] SRAM_WRITE_ADDRESS;
   logic [DW-1:0]        SRAM_WRITE_DATA;
   logic [NB-1:0]        SRAM_WRITE_BYTE_ENABLE;
   logic                 SRAM_WRITE_STROBE;

   modport master (
      output SRAM_READ_ADDRESS, SRAM_OUTPUT_ENABLE,
      input  SRAM_READ_DATA,
      output SRAM_WRITE_ADDRESS, SRAM_WRITE_DATA, SRAM_WRITE_BYTE_ENABLE, SRAM_WRITE_STROBE
   );

   modport slave (
      input  SRAM_READ_ADDRESS, SRAM_OUTPUT_ENABLE,
      output SRAM_READ_DATA,
      input  SRAM_WRITE_ADDRESS, SRAM_WRITE_DATA, SRAM_WRITE_BYTE_ENABLE, SRAM_WRITE_STROBE
   );
endinterface

// File: rtl/sram_word_store.sv
// Single-bank word store with post-reset zero-clear, write-first forwarding, range check, counters.
// Latency: read data registered, valid one edge after OE; writes take effect at their edge.
// Backpressure: never stalls; accesses during the clear sweep are dropped and flagged in ERR.
module sram_word_store #(
   parameter int addr_bits = 19,
   parameter int p_size    = 3,
   parameter int depth     = 4096,
   parameter int init_zero = 1
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   sram_word_store_if.slave   bus,
   output logic               INIT_DONE,
   output logic               ERR,
   output logic [31:0]        RD_COUNT,
   output logic [31:0]        WR_COUNT
);
   localparam int DW = 8 << p_size;
   localparam int NB = 1 << p_size;
   localparam int IW = (depth > 1) ? $clog2(depth) : 1;
   // One bit wider than the address so depth == 2^addr_bits still compares correctly.
   localparam logic [addr_bits:0] LIMIT = (addr_bits + 1)'(depth);

   typedef enum logic {CLEAR, READY} state_t;

   state_t         state_q, state_d;
   logic           clearing;
   logic [IW-1:0]  clr_ptr;
   logic           clr_last;

   logic [DW-1:0]  mem [depth];
   logic           mem_we;
   logic [IW-1:0]  mem_waddr;
   logic [DW-1:0]  mem_wdat;
   logic [NB-1:0]  mem_wbe;

   logic           rd_in_range, wr_in_range;
   logic           rd_ok, wr_ok;
   logic [IW-1:0]  rd_idx, wr_idx;
   logic [DW-1:0]  mem_rdat, rd_next;
   logic [DW-1:0]  rd_q;
   logic           err_q, err_set;
   logic [31:0]    rd_cnt, wr_cnt;

   assign clr_last    = (clr_ptr == IW'(depth - 1));
   assign rd_in_range = ({1'b0, bus.SRAM_READ_ADDRESS} < LIMIT);
   assign wr_in_range = ({1'b0, bus.SRAM_WRITE_ADDRESS} < LIMIT);
   assign rd_idx      = bus.SRAM_READ_ADDRESS[IW-1:0];
   assign wr_idx      = bus.SRAM_WRITE_ADDRESS[IW-1:0];
   assign rd_ok       = INIT_DONE && bus.SRAM_OUTPUT_ENABLE && rd_in_range;
   assign wr_ok       = INIT_DONE && bus.SRAM_WRITE_STROBE && wr_in_range;

   // State register: reset chooses whether a clear sweep runs.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) state_q <= (init_zero != 0) ? CLEAR : READY;
      else          state_q <= state_d;
   end

   // Next state: leave CLEAR on the edge that zeroes the last word.
   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && clr_last) state_d = READY;
   end

   // FSM outputs.
   always_comb begin
      INIT_DONE = (state_q == READY);
      clearing  = (state_q == CLEAR);
   end

   // Clear pointer walks the array once per sweep; restarts at every reset.
   always_ff @(posedge ACLK) begin
      if (!ARESETn)      clr_ptr <= '0;
      else if (clearing) clr_ptr <= clr_ptr + 1'b1;
   end

   // Single write port shared by the clear sweep and port writes; nothing lands on a reset edge.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_idx;
      mem_wdat  = bus.SRAM_WRITE_DATA;
      mem_wbe   = bus.SRAM_WRITE_BYTE_ENABLE;
      if (clearing) begin
         mem_we    = ARESETn;
         mem_waddr = clr_ptr;
         mem_wdat  = '0;
         mem_wbe   = '1;
      end else if (wr_ok) begin
         mem_we    = ARESETn;
      end
   end

   // Byte-lane write into the array (no reset on contents).
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdat[8*b +: 8];
         end
      end
   end

   assign mem_rdat = mem[rd_idx];

   // Write-first merge: a same-edge write to the read address overrides the enabled lanes.
   always_comb begin
      rd_next = mem_rdat;
      if (wr_ok && rd_ok && (wr_idx == rd_idx)) begin
         for (int b = 0; b < NB; b++) begin
            if (bus.SRAM_WRITE_BYTE_ENABLE[b]) rd_next[8*b +: 8] = bus.SRAM_WRITE_DATA[8*b +: 8];
         end
      end
   end

   // Registered read data: zero while clearing, all-ones when out of range, else holds without OE.
   always_ff @(posedge ACLK) begin
      if (!ARESETn)                           rd_q <= '0;
      else if (clearing && bus.SRAM_OUTPUT_ENABLE) rd_q <= '0;
      else if (INIT_DONE && bus.SRAM_OUTPUT_ENABLE) rd_q <= rd_in_range ? rd_next : {DW{1'b1}};
   end

   assign bus.SRAM_READ_DATA = rd_q;

   // Error causes: any port access while clearing, or an out-of-range access once ready.
   always_comb begin
      err_set = 1'b0;
      if (clearing && (bus.SRAM_OUTPUT_ENABLE || bus.SRAM_WRITE_STROBE)) err_set = 1'b1;
      if (INIT_DONE && bus.SRAM_OUTPUT_ENABLE && !rd_in_range)          err_set = 1'b1;
      if (INIT_DONE && bus.SRAM_WRITE_STROBE && !wr_in_range)           err_set = 1'b1;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge ACLK) begin
      if (!ARESETn)     err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   // Saturating counters of accepted reads and writes.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_ok && rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 32'd1;
         if (wr_ok && wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
      end
   end

   assign ERR      = err_q;
   assign RD_COUNT = rd_cnt;
   assign WR_COUNT = wr_cnt;
endmodule

// File: tb/tb_sram_word_store.sv
// Self-checking bench for sram_word_store: clear sweep, byte lanes, forwarding, range, counters.
// Latency: inputs driven 1ns after an edge, outputs compared 1ns after the following edge.
// Backpressure: none; the store accepts every cycle, so the bench drives freely.
module tb_sram_word_store;
   localparam int DEPTH = 16;

   logic ACLK;
   logic ARESETn;
   logic INIT_DONE, ERR;
   logic [31:0] RD_COUNT, WR_COUNT;

   sram_word_store_if #(.addr_bits(19), .p_size(3)) bus ();

   sram_word_store #(.addr_bits(19), .p_size(3), .depth(DEPTH), .init_zero(1)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .bus       (bus.slave),
      .INIT_DONE (INIT_DONE),
      .ERR       (ERR),
      .RD_COUNT  (RD_COUNT),
      .WR_COUNT  (WR_COUNT)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic        oe;
      int          ra;
      logic        we;
      int          wa;
      logic [63:0] wd;
      logic [7:0]  be;
      logic [63:0] e_rd;
      logic        e_err;
      int unsigned e_rdc;
      int unsigned e_wrc;
   } vec_t;

   vec_t tbl [14];

   int n_vec, n_fail;

   // Reference model: the store as an array of words plus flags, updated per accepted edge.
   logic [63:0] m_mem [DEPTH];
   logic [63:0] m_rd;
   logic        m_err;
   logic [31:0] m_rdc, m_wrc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic drive(input logic oe, input int ra, input logic we, input int wa,
                        input logic [63:0] wd, input logic [7:0] be);
      bus.SRAM_OUTPUT_ENABLE     = oe;
      bus.SRAM_READ_ADDRESS      = 19'(ra);
      bus.SRAM_WRITE_STROBE      = we;
      bus.SRAM_WRITE_ADDRESS     = 19'(wa);
      bus.SRAM_WRITE_DATA        = wd;
      bus.SRAM_WRITE_BYTE_ENABLE = be;
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_rd  = '0;
      m_err = 1'b0;
      m_rdc = '0;
      m_wrc = '0;
   endtask

   // One ready-state edge: the write lands first, so a same-address read sees it.
   task automatic model_edge(input logic oe, input int ra, input logic we, input int wa,
                             input logic [63:0] wd, input logic [7:0] be);
      logic [63:0] w;
      if (we) begin
         if (wa < DEPTH) begin
            w = m_mem[wa];
            for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            m_mem[wa] = w;
            if (m_wrc != 32'hFFFF_FFFF) m_wrc = m_wrc + 1;
         end else m_err = 1'b1;
      end
      if (oe) begin
         if (ra < DEPTH) begin
            m_rd = m_mem[ra];
            if (m_rdc != 32'hFFFF_FFFF) m_rdc = m_rdc + 1;
         end else begin
            m_rd  = '1;
            m_err = 1'b1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_rd_data"},  bus.SRAM_READ_DATA, m_rd);
      chk({tag, "_err"},      64'(ERR),           64'(m_err));
      chk({tag, "_rd_count"}, 64'(RD_COUNT),      64'(m_rdc));
      chk({tag, "_wr_count"}, 64'(WR_COUNT),      64'(m_wrc));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic oe, we;
      int ra, wa;
      logic [63:0] wd;
      logic [7:0] be;

      //            oe    ra  we    wa  wd                      be     exp rd                  err   rdc wrc
      tbl[0]  = '{1'b0,  0, 1'b1,  3, 64'h1122334455667788, 8'hFF, 64'h0,                  1'b0, 1, 1};
      tbl[1]  = '{1'b0,  0, 1'b1,  3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0,                  1'b0, 1, 2};
      tbl[2]  = '{1'b1,  3, 1'b0,  0, 64'h0,                8'h00, 64'h11223344AAAAAAAA,   1'b0, 2, 2};
      tbl[3]  = '{1'b0,  0, 1'b1,  7, 64'h0,                8'hFF, 64'h11223344AAAAAAAA,   1'b0, 2, 3};
      tbl[4]  = '{1'b1,  7, 1'b1,  7, 64'hFF,               8'h01, 64'h00000000000000FF,   1'b0, 3, 4};
      tbl[5]  = '{1'b1,  7, 1'b1,  7, 64'h123456789ABCDEF0, 8'h00, 64'h00000000000000FF,   1'b0, 4, 5};
      tbl[6]  = '{1'b1,  3, 1'b1,  9, 64'h55,               8'hFF, 64'h11223344AAAAAAAA,   1'b0, 5, 6};
      tbl[7]  = '{1'b1,  9, 1'b0,  0, 64'h0,                8'h00, 64'h55,                 1'b0, 6, 6};
      tbl[8]  = '{1'b0,  0, 1'b0,  0, 64'h0,                8'h00, 64'h55,                 1'b0, 6, 6};
      tbl[9]  = '{1'b1, 20, 1'b0,  0, 64'h0,                8'h00, 64'hFFFFFFFFFFFFFFFF,   1'b1, 6, 6};
      tbl[10] = '{1'b1,  9, 1'b0,  0, 64'h0,                8'h00, 64'h55,                 1'b1, 7, 6};
      tbl[11] = '{1'b0,  0, 1'b1, 16, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h55,                 1'b1, 7, 6};
      tbl[12] = '{1'b1, 15, 1'b1, 15, 64'hA5,               8'h01, 64'hA5,                 1'b1, 8, 7};
      tbl[13] = '{1'b1,  0, 1'b0,  0, 64'h0,                8'h00, 64'h0,                  1'b1, 9, 7};

      n_vec  = 0;
      n_fail = 0;

      // Reset with a backdoor value in word 5 that the sweep must wipe.
      drive(0, 0, 0, 0, 64'h0, 8'h00);
      ARESETn = 1'b0;
      tick();
      tick();
      dut.mem[5] = 64'hDEAD_BEEF_0123_4567;
      chk("reset_init_done", 64'(INIT_DONE), 64'd0);
      chk("reset_err",       64'(ERR),       64'd0);
      chk("reset_rd_count",  64'(RD_COUNT),  64'd0);
      chk("reset_wr_count",  64'(WR_COUNT),  64'd0);
      chk("reset_rd_data",   bus.SRAM_READ_DATA, 64'd0);

      // Clear sweep: edges 0..15, INIT_DONE only after edge 15.
      ARESETn = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         tick();
         chk($sformatf("sweep_init_done_e%0d", k), 64'(INIT_DONE), 64'(k == DEPTH - 1));
      end

      model_reset();
      drive(1, 5, 0, 0, 64'h0, 8'h00);
      model_edge(1, 5, 0, 0, 64'h0, 8'h00);
      tick();
      chk("cleared_word5", bus.SRAM_READ_DATA, 64'h0);
      check_model("first_read");

      // Directed vectors: byte lanes, forwarding, BE=0, range boundary, aliasing.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].oe, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be);
         model_edge(tbl[i].oe, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be);
         tick();
         chk($sformatf("vec%0d_rd_data", i),  bus.SRAM_READ_DATA, tbl[i].e_rd);
         chk($sformatf("vec%0d_err", i),      64'(ERR),           64'(tbl[i].e_err));
         chk($sformatf("vec%0d_rd_count", i), 64'(RD_COUNT),      64'(tbl[i].e_rdc));
         chk($sformatf("vec%0d_wr_count", i), 64'(WR_COUNT),      64'(tbl[i].e_wrc));
      end

      // Random traffic, including out-of-range addresses and forced same-address collisions.
      for (int c = 0; c < 300; c++) begin
         oe = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         ra = int'($urandom_range(0, 19));
         wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 19));
         wd = {$urandom, $urandom};
         be = 8'($urandom);
         drive(oe, ra, we, wa, wd, be);
         model_edge(oe, ra, we, wa, wd, be);
         tick();
         check_model($sformatf("rand%0d", c));
      end

      // Write counter saturation, writes aimed at word 12 with non-zero data.
      dut.wr_cnt = 32'hFFFF_FFFE;
      m_wrc      = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 12, 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF);
         model_edge(0, 0, 1, 12, 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF);
         tick();
         check_model($sformatf("sat%0d", i));
      end
      chk("wr_count_saturated", 64'(WR_COUNT), 64'hFFFF_FFFF);

      // Accesses during CLEAR, then reset in the middle of the sweep.
      drive(0, 0, 0, 0, 64'h0, 8'h00);
      ARESETn = 1'b0;
      tick();
      chk("reset2_err",       64'(ERR),       64'd0);
      chk("reset2_wr_count",  64'(WR_COUNT),  64'd0);
      ARESETn = 1'b1;
      tick();
      tick();
      drive(1, 1, 0, 0, 64'h0, 8'h00);
      tick();
      drive(0, 0, 0, 0, 64'h0, 8'h00);
      chk("clear_read_err", 64'(ERR), 64'd1);
      chk("clear_read_rd_count", 64'(RD_COUNT), 64'd0);
      tick();
      drive(0, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      tick();
      drive(0, 0, 0, 0, 64'h0, 8'h00);
      chk("clear_write_wr_count",  64'(WR_COUNT),  64'd0);
      chk("clear_write_err",       64'(ERR),       64'd1);
      chk("clear_write_init_done", 64'(INIT_DONE), 64'd0);
      tick();
      tick();
      tick();
      ARESETn = 1'b0;
      tick();
      chk("midclear_reset_err",       64'(ERR),       64'd0);
      chk("midclear_reset_init_done", 64'(INIT_DONE), 64'd0);
      ARESETn = 1'b1;
      n = 0;
      while (!INIT_DONE && n < 40) begin
         tick();
         n++;
      end
      chk("restart_sweep_edges", 64'(n), 64'd16);

      model_reset();
      drive(1, 12, 0, 0, 64'h0, 8'h00);
      model_edge(1, 12, 0, 0, 64'h0, 8'h00);
      tick();
      check_model("after_restart_w12");
      drive(1, 2, 0, 0, 64'h0, 8'h00);
      model_edge(1, 2, 0, 0, 64'h0, 8'h00);
      tick();
      check_model("after_restart_w2");
      drive(0, 0, 0, 0, 64'h0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
